// File: rtl/mul_sequencer.sv
// -----------------------------------------------------------------------------
// mul_sequencer
//
// Iterative unsigned multiplier controller. It has no adder of its own: while
// a multiply is in flight it borrows the shared execute-stage ALU, performs
// WIDTH shift-add iterations through it, and stalls the pipeline meanwhile.
// The low WIDTH bits of the product are returned with a one-cycle done pulse.
//
// Optional build macro:
//   MUL_EARLY_EXIT_EN - leave RUN as soon as the remaining multiplier bits are
//                       all zero, instead of always running WIDTH iterations.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      multiply request, sampled only in IDLE
//   op_a       multiplicand, captured on an accepted start
//   op_b       multiplier, captured on an accepted start
//   alu_req    sequencer owns the ALU (steers the ALU input muxes)
//   alu_a      ALU operand a (accumulator), zero when not owning the ALU
//   alu_b      ALU operand b (multiplicand or zero), zero when not owning
//   alu_ctrl   ALU control, always ALU_ADD
//   alu_result ALU result, combinational from alu_a/alu_b
//   busy       high in RUN and DONE
//   stall      pipeline stall: accepted start in IDLE, or RUN
//   done       one-cycle pulse, product valid
//   product    low WIDTH bits of op_a*op_b, held until the next result
// -----------------------------------------------------------------------------
module mul_sequencer #(
    parameter int         WIDTH   = 64,
    parameter logic [3:0] ALU_ADD = 4'b0010
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             alu_req,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic             last_iter;

    // The current RUN cycle is the final iteration.
`ifdef MUL_EARLY_EXIT_EN
    // Once the multiplier shifted right is zero, further iterations would
    // only add zero, so the accumulator already holds the product.
    assign last_iter = (cnt == LAST) || (mplier[WIDTH-1:1] == '0);
`else
    assign last_iter = (cnt == LAST);
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values; blocking here would create ordering races.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and output decode.
    always_comb begin
        // NOTE: every output gets a default before the case so that no path
        // leaves a signal unassigned, which would infer a latch.
        state_nxt = state;
        alu_req   = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_ctrl  = ALU_ADD;
        busy      = 1'b0;
        stall     = 1'b0;
        done      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    stall     = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                alu_req = 1'b1;
                busy    = 1'b1;
                stall   = 1'b1;
                alu_a   = acc;
                alu_b   = mplier[0] ? mcand : '0;
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // ALU is released here, so the pipeline may resume while the
                // result is presented.
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        // NOTE: these are plain registers, not a memory array, so each one is
        // reset explicitly; an aborted multiply leaves nothing behind.
        if (reset) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        mcand  <= op_a;
                        mplier <= op_b;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    acc    <= alu_result;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last_iter) begin
                        product <= alu_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mul_sequencer
//
// Directed bench for mul_sequencer. A behavioural ALU (add on ALU_ADD) closes
// the loop. Cycle 0 is the cycle in which start is presented in IDLE; outputs
// are sampled 2 time units after each rising edge.
// Expected latencies follow the MUL_EARLY_EXIT_EN build of the bench.
// -----------------------------------------------------------------------------
module tb_mul_sequencer;

    localparam int         WIDTH   = 64;
    localparam logic [3:0] ALU_ADD = 4'b0010;
`ifdef MUL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             alu_req;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] product;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Shared ALU stand-in: only the add op is meaningful here.
    assign alu_result = (alu_ctrl == ALU_ADD) ? (alu_a + alu_b) : {WIDTH{1'b1}};

    mul_sequencer #(.WIDTH(WIDTH), .ALU_ADD(ALU_ADD)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .alu_req    (alu_req),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .busy       (busy),
        .stall      (stall),
        .done       (done),
        .product    (product)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Issues one multiply from IDLE and records what happens until the cycle
    // after done (or until the cycle budget runs out).
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          output logic stall0, output int done_cyc,
                          output int done_cnt, output int req_cnt,
                          output int req_first, output int req_last,
                          output int bad, output logic [WIDTH-1:0] prod,
                          output logic busy_after);
        done_cyc   = -1;
        done_cnt   = 0;
        req_cnt    = 0;
        req_first  = -1;
        req_last   = -1;
        bad        = 0;
        prod       = 'x;
        busy_after = 1'bx;
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        #1;
        stall0 = stall;
        tick();
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        for (int cyc = 1; cyc <= WIDTH + 4; cyc++) begin
            if (alu_req === 1'b1) begin
                req_cnt++;
                if (req_first < 0) req_first = cyc;
                req_last = cyc;
                if (alu_ctrl !== ALU_ADD || stall !== 1'b1 || busy !== 1'b1) bad++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    prod     = product;
                end
                if (stall !== 1'b0 || busy !== 1'b1 || alu_req !== 1'b0) bad++;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                busy_after = busy;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || alu_req !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: busy=%b done=%b alu_req=%b stall=%b, want all 0",
                     busy, done, alu_req, stall);
        end
        checks++;
        if (product !== '0) begin
            failures++;
            $display("FAIL reset_product: got %h want 0", product);
        end
        checks++;
        if (alu_a !== '0 || alu_b !== '0 || alu_ctrl !== ALU_ADD) begin
            failures++;
            $display("FAIL reset_alu_idle: a=%h b=%h ctrl=%b want 0/0/%b",
                     alu_a, alu_b, alu_ctrl, ALU_ADD);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b done=%b want 0/0", busy, done);
        end
    endtask

    task automatic test_basic();
        logic             s0;
        logic             ba;
        int               dc;
        int               dn;
        int               rc;
        int               rf;
        int               rl;
        int               bad;
        logic [WIDTH-1:0] p;
        int               exp_done;
        exp_done = EARLY ? 4 : 65;
        run_op(64'd3, 64'd5, s0, dc, dn, rc, rf, rl, bad, p, ba);
        checks++;
        if (s0 !== 1'b1) begin
            failures++;
            $display("FAIL basic_stall_c0: got %b want 1", s0);
        end
        checks++;
        if (dc != exp_done || dn != 1) begin
            failures++;
            $display("FAIL basic_done: cycle=%0d pulses=%0d want cycle=%0d pulses=1",
                     dc, dn, exp_done);
        end
        checks++;
        if (rf != 1 || rl != exp_done - 1 || rc != exp_done - 1) begin
            failures++;
            $display("FAIL basic_alu_req: first=%0d last=%0d count=%0d want 1/%0d/%0d",
                     rf, rl, rc, exp_done - 1, exp_done - 1);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL basic_run_flags: %0d bad cycles, want 0", bad);
        end
        checks++;
        if (p !== 64'd15) begin
            failures++;
            $display("FAIL basic_product: got %0d want 15", p);
        end
        checks++;
        if (ba !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy_after: got %b want 0", ba);
        end
    endtask

    // Wrap-around, zero operands and multiplier-length cases.
    task automatic test_products();
        logic [WIDTH-1:0] va[8];
        logic [WIDTH-1:0] vb[8];
        logic [WIDTH-1:0] vp[8];
        int               vd[8];
        logic             s0;
        logic             ba;
        int               dc;
        int               dn;
        int               rc;
        int               rf;
        int               rl;
        int               bad;
        logic [WIDTH-1:0] p;
        va[0] = 64'hFFFF_FFFF_FFFF_FFFF; vb[0] = 64'd2;
        vp[0] = 64'hFFFF_FFFF_FFFF_FFFE; vd[0] = EARLY ? 3 : 65;
        va[1] = 64'h8000_0000_0000_0000; vb[1] = 64'd2;
        vp[1] = 64'd0;                   vd[1] = EARLY ? 3 : 65;
        va[2] = 64'd0;                   vb[2] = 64'd123;
        vp[2] = 64'd0;                   vd[2] = EARLY ? 8 : 65;
        va[3] = 64'd5;                   vb[3] = 64'd0;
        vp[3] = 64'd0;                   vd[3] = EARLY ? 2 : 65;
        va[4] = 64'd7;                   vb[4] = 64'd3;
        vp[4] = 64'd21;                  vd[4] = EARLY ? 3 : 65;
        va[5] = 64'd5;                   vb[5] = 64'h8000_0000_0000_0000;
        vp[5] = 64'h8000_0000_0000_0000; vd[5] = 65;
        va[6] = 64'hFFFF_FFFF_FFFF_FFFF; vb[6] = 64'hFFFF_FFFF_FFFF_FFFF;
        vp[6] = 64'd1;                   vd[6] = 65;
        va[7] = 64'd1234567;             vb[7] = 64'd7654321;
        vp[7] = 64'd9449772114007;       vd[7] = EARLY ? 24 : 65;
        for (int i = 0; i < 8; i++) begin
            run_op(va[i], vb[i], s0, dc, dn, rc, rf, rl, bad, p, ba);
            checks++;
            if (p !== vp[i]) begin
                failures++;
                $display("FAIL product[%0d]: %h*%h got %h want %h", i, va[i], vb[i], p, vp[i]);
            end
            checks++;
            if (dc != vd[i] || dn != 1 || rc != vd[i] - 1) begin
                failures++;
                $display("FAIL latency[%0d]: done_cycle=%0d pulses=%0d req_cycles=%0d want %0d/1/%0d",
                         i, dc, dn, rc, vd[i], vd[i] - 1);
            end
            checks++;
            if (s0 !== 1'b1 || bad != 0 || ba !== 1'b0) begin
                failures++;
                $display("FAIL handshake[%0d]: stall_c0=%b bad=%0d busy_after=%b want 1/0/0",
                         i, s0, bad, ba);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int mid;
        int exp_done;
        int dc;
        int dn;
        int bad;
        int late_done;
        int late_busy;
        logic [WIDTH-1:0] p;
        logic ba;
        mid      = EARLY ? 2 : 10;
        exp_done = EARLY ? 4 : 65;
        dc  = -1;
        dn  = 0;
        bad = 0;
        p   = 'x;
        ba  = 1'bx;
        start = 1'b1;
        op_a  = 64'd7;
        op_b  = 64'd6;
        tick();
        for (int cyc = 1; cyc <= WIDTH + 4; cyc++) begin
            start = (cyc == mid || cyc == exp_done);
            op_a  = 64'd9;
            op_b  = 64'd9;
            #1;
            if (done === 1'b1) begin
                dn++;
                if (dc < 0) begin
                    dc = cyc;
                    p  = product;
                end
                if (stall !== 1'b0) bad++;
            end
            if (dc >= 0 && cyc == dc + 1) begin
                ba = busy;
                break;
            end
            tick();
        end
        start = 1'b0;
        checks++;
        if (dc != exp_done || dn != 1 || p !== 64'd42) begin
            failures++;
            $display("FAIL busy_first_op: done_cycle=%0d pulses=%0d product=%0d want %0d/1/42",
                     dc, dn, p, exp_done);
        end
        checks++;
        if (ba !== 1'b0 || bad != 0) begin
            failures++;
            $display("FAIL busy_drop: busy_after=%b done_with_stall=%0d want 0/0", ba, bad);
        end
        late_done = 0;
        late_busy = 0;
        for (int i = 0; i < WIDTH + 6; i++) begin
            tick();
            if (done === 1'b1) late_done++;
            if (busy === 1'b1) late_busy++;
        end
        checks++;
        if (late_done != 0 || late_busy != 0 || product !== 64'd42) begin
            failures++;
            $display("FAIL busy_ignored_starts: dones=%0d busy_cycles=%0d product=%0d want 0/0/42",
                     late_done, late_busy, product);
        end
    endtask

    task automatic test_reset_mid_op();
        int rcyc;
        int stray;
        logic s0;
        logic ba;
        int dc;
        int dn;
        int rc;
        int rf;
        int rl;
        int bad;
        logic [WIDTH-1:0] p;
        rcyc  = EARLY ? 4 : 30;
        start = 1'b1;
        op_a  = 64'd100;
        op_b  = 64'd100;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc < rcyc; cyc++) tick();
        checks++;
        if (busy !== 1'b1 || alu_req !== 1'b1) begin
            failures++;
            $display("FAIL mid_op_running: busy=%b alu_req=%b want 1/1", busy, alu_req);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || alu_req !== 1'b0 || done !== 1'b0 || product !== '0) begin
            failures++;
            $display("FAIL mid_op_reset: busy=%b alu_req=%b done=%b product=%h want 0/0/0/0",
                     busy, alu_req, done, product);
        end
        reset = 1'b0;
        stray = 0;
        for (int i = 0; i < WIDTH + 6; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL mid_op_no_done: %0d active cycles after reset, want 0", stray);
        end
        run_op(64'd4, 64'd4, s0, dc, dn, rc, rf, rl, bad, p, ba);
        checks++;
        if (p !== 64'd16 || dc != (EARLY ? 4 : 65) || dn != 1) begin
            failures++;
            $display("FAIL post_reset_op: product=%0d done_cycle=%0d pulses=%0d want 16/%0d/1",
                     p, dc, dn, EARLY ? 4 : 65);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        test_reset();
        test_basic();
        test_products();
        test_start_while_busy();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Iterative 64-bit unsigned multiplier controller for the pipelined core (MUL support).
- Has no adder of its own. It borrows the shared execute-stage ALU for WIDTH shift-add iterations, using ALU add op 4'b0010.
- Raises a stall to the hazard unit while it owns the ALU.
- Returns the low WIDTH bits of the product with a done pulse.

Parameters:
- WIDTH, 64, operand, accumulator and product width; must match the ALU width.
- ALU_ADD, 4'b0010, ALUControl code driven to the ALU during iterations.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request a multiply; sampled only in IDLE
- op_a  in  WIDTH  multiplicand, captured at start
- op_b  in  WIDTH  multiplier, captured at start
- alu_req  out  1  high while the sequencer owns the ALU; selects sequencer inputs at the ALU muxes
- alu_a  out  WIDTH  ALU operand a (accumulator)
- alu_b  out  WIDTH  ALU operand b (multiplicand or zero)
- alu_ctrl  out  4  ALU control; constant ALU_ADD
- alu_result  in  WIDTH  ALU result, combinational from alu_a/alu_b
- busy  out  1  high in RUN and DONE
- stall  out  1  combinational: (state==IDLE & start) | (state==RUN)
- done  out  1  one-cycle pulse; product valid
- product  out  WIDTH  low WIDTH bits of op_a*op_b; held until the next accepted start

Behaviour:
- States are IDLE, RUN and DONE. Internal registers: acc (WIDTH), mcand (WIDTH), mplier (WIDTH), cnt (clog2(WIDTH) bits).
- Reset: state=IDLE, acc=mcand=mplier=cnt=0, product=0, done=0, busy=0, alu_req=0. Reset wins over every other event, including mid-RUN; the in-flight operation is discarded and no done is produced.
- IDLE with start=1 (cycle 0): acc<=0, mcand<=op_a, mplier<=op_b, cnt<=0, next state RUN. stall=1 in cycle 0.
- IDLE with start=0: all registers hold.
- RUN, each cycle:
  - alu_req=1, alu_a=acc, alu_b = mplier[0] ? mcand : 0, alu_ctrl=ALU_ADD.
  - Register updates: acc<=alu_result, mcand<=mcand<<1 (MSB discarded), mplier<=mplier>>1 (logical), cnt<=cnt+1.
- RUN exit: when cnt==WIDTH-1, the next state is DONE and product<=alu_result. Otherwise stay in RUN.
- DONE: lasts one cycle. done=1, busy=1, alu_req=0, stall=0. Next state is IDLE.
- Latency without the optional feature: start at cycle 0, RUN for cycles 1..WIDTH, done at cycle WIDTH+1 (cycle 65 at WIDTH=64).
- start is ignored in RUN and DONE; no queueing. start in the DONE cycle is lost; a new start is accepted only in IDLE.
- Arithmetic: unsigned, modulo 2^WIDTH. High product bits and mcand shift-out are discarded; there is no overflow flag.
- When alu_req=0: alu_a=0, alu_b=0, alu_ctrl=ALU_ADD. The pipeline muxes ignore these values.
- product changes only on the RUN->DONE transition or on reset.
- done never asserts together with stall.

Optional Feature:
- Macro: MUL_EARLY_EXIT_EN.
- Defined: RUN also exits to DONE after any iteration whose shifted multiplier (mplier>>1) is zero; product<=alu_result on that transition. At least one RUN cycle always occurs, so done arrives at cycle k+1, where k = max(1, bit index of the highest set bit of op_b plus 1). op_b=0 gives done at cycle 2.
- Not defined: fixed WIDTH iterations as above; the early-exit logic is absent.

Test Plan:
- Basic: reset, then start with op_a=3, op_b=5 → stall=1 in cycle 0; alu_req=1 in cycles 1..64; done=1 only in cycle 65; product=15.
- Wrap: op_a=64'hFFFF_FFFF_FFFF_FFFF, op_b=2 → product=64'hFFFF_FFFF_FFFF_FFFE; op_a=2^63, op_b=2 → product=0.
- Start while busy: start in cycles 0 (op_a=7, op_b=6), 10 and 65 (op_a=9, op_b=9) → only the first is accepted; product=42 at cycle 65; busy drops at cycle 66; 9*9 is never computed.
- Reset mid-op: start 100*100, assert reset in cycle 30 → cycle 31: state IDLE, busy=0, alu_req=0, product=0; no done pulse follows. A new start 4*4 then gives product=16.
- Zero operand: op_a=0, op_b=123 → product=0 and done at cycle 65. With MUL_EARLY_EXIT_EN, op_b=0 → done at cycle 2, product=0.
- MUL_EARLY_EXIT_EN: op_a=7, op_b=3 → RUN in cycles 1..2, done at cycle 3, product=21; op_b=2^63 → done at cycle 65.
